l2_bank_tcdm_adapter: RTL

//  Front end for one L2 SRAM bank. Arbitrates two TCDM-style masters (req/gnt/r_valid) onto a single

---
 rtl/l2_bank_tcdm_adapter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/l2_bank_tcdm_adapter.sv
// Two-master TCDM front end for one L2 SRAM bank: round-robin arbitration onto a
// UNICAD-style port, 1-cycle responses, out-of-range flagging and bank zero-fill.
module l2_bank_tcdm_adapter #(
  parameter int ADDR_WIDTH    = 14,
  parameter int BANK_WORDS    = 16384,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       init_ni,
  output logic                       init_done_o,
  input  logic [1:0]                 req_i,
  input  logic [1:0]                 wen_i,
  input  logic [1:0][ADDR_WIDTH-1:0] add_i,
  input  logic [1:0][3:0]            be_i,
  input  logic [1:0][31:0]           wdata_i,
  output logic [1:0]                 gnt_o,
  output logic [1:0]                 r_valid_o,
  output logic [1:0]                 r_opc_o,
  output logic [1:0][31:0]           r_rdata_o,
  output logic                       mem_csn_o,
  output logic                       mem_wen_o,
  output logic [3:0]                 mem_be_o,
  output logic [ADDR_WIDTH-1:0]      mem_add_o,
  output logic [31:0]                mem_wdata_o,
  input  logic [31:0]                mem_rdata_i
);

  typedef enum logic [1:0] {BOOT, INIT, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BANK_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   WORDS     = (ADDR_WIDTH + 1)'(BANK_WORDS);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < WORDS;
  endfunction

  state_t                state;
  logic                  rr_ptr;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  init_q;
  logic                  init_fall;
  logic                  serve;
  logic                  sel_p0;
  logic                  granted_p0;
  logic                  hit_p0;
  logic                  vld_p1;
  logic                  idx_p1;
  logic                  rd_p1;
  logic                  err_p1;

  assign init_fall   = init_q & ~init_ni;
  assign serve       = (state == RUN) && !init_fall;
  assign init_done_o = (state == RUN);

  // Stage p0: arbitration and combinational drive of the bank port
  always_comb begin
    gnt_o  = '0;
    sel_p0 = (&req_i) ? rr_ptr : req_i[1];
    if (serve && req_i[sel_p0]) gnt_o[sel_p0] = 1'b1;
  end

  assign granted_p0 = |gnt_o;
  assign hit_p0     = in_range(add_i[sel_p0]);

  always_comb begin
    mem_csn_o   = 1'b1;
    mem_wen_o   = 1'b1;
    mem_be_o    = '0;
    mem_add_o   = '0;
    mem_wdata_o = '0;
    if (state == INIT) begin
      mem_csn_o = 1'b0;
      mem_wen_o = 1'b0;
      mem_be_o  = 4'hF;
      mem_add_o = cnt;
    end else if (granted_p0 && hit_p0) begin
      mem_csn_o   = 1'b0;
      mem_wen_o   = wen_i[sel_p0];
      mem_be_o    = be_i[sel_p0];
      mem_add_o   = add_i[sel_p0];
      mem_wdata_o = wdata_i[sel_p0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= BOOT;
      rr_ptr <= 1'b0;
      cnt    <= '0;
      init_q <= 1'b1;
      vld_p1 <= 1'b0;
      idx_p1 <= 1'b0;
      rd_p1  <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      init_q <= init_ni;
      vld_p1 <= granted_p0;
      idx_p1 <= sel_p0;
      rd_p1  <= wen_i[sel_p0];
      err_p1 <= !hit_p0;
      if ((&req_i) && granted_p0) rr_ptr <= ~sel_p0;
      case (state)
        BOOT: state <= INIT_ON_RESET ? INIT : RUN;
        INIT: begin
          if (cnt == LAST_ADDR) begin
            cnt   <= '0;
            state <= RUN;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        RUN:     if (init_fall) state <= INIT;
        default: state <= BOOT;
      endcase
    end
  end

  // Stage p1: response steered back to the master granted last cycle
  always_comb begin
    r_valid_o = '0;
    r_opc_o   = '0;
    r_rdata_o = '0;
    if (vld_p1) begin
      r_valid_o[idx_p1] = 1'b1;
      r_opc_o[idx_p1]   = err_p1;
      r_rdata_o[idx_p1] = (rd_p1 && !err_p1) ? mem_rdata_i : '0;
    end
  end

endmodule
